conv1d_window_buf: RTL and testbench

Streaming sliding-window assembler that feeds the convolution PE. It accepts one Q-format activation per handshake, keeps the last N_REG samples in a shift register, and applies implicit zero padding of PAD on each side. Each time a stride-aligned window is complete, it presents all N_REG samples in parallel on win_data, packed exactly as the PE's all_a bus. It sits directly upstream of the PE in the encoder path (kernel 31, stride 2, "same" padding).

---
 rtl/conv1d_window_buf.sv | 178 +++++++++++++++++
 tb/tb_conv1d_window_buf.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_window_buf.sv
// rtl/conv1d_window_buf.sv - streaming sliding-window assembler with implicit zero padding
//
// Accepts one sample per in_valid/in_ready handshake into an N_REG-deep shift
// register and presents a full window in parallel each time a stride-aligned
// window (including PAD zeros on both frame edges) is complete.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   in_data       input sample (WIDTH bits)
//   in_valid      in_data valid
//   in_first      beat is the first sample of a frame
//   in_last       beat is the last sample of a frame
//   in_ready      block accepts a beat this cycle (FILL state only)
//   win_data      window, slot k at [k*WIDTH +: WIDTH], slot 0 oldest
//   win_valid     win_data valid, held stable until win_ready
//   win_last      current window is the frame's final window
//   win_ready     downstream consumes the window
//   frame_done    one-cycle pulse after the final window handshake
module conv1d_window_buf #(
    parameter int WIDTH   = 32,
    parameter int N_REG   = 31,
    parameter int STRIDE  = 2,
    parameter int PAD     = 15,
    parameter int MAX_LEN = 16384
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    input  logic                   in_first,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [N_REG*WIDTH-1:0] win_data,
    output logic                   win_valid,
    output logic                   win_last,
    input  logic                   win_ready,
    output logic                   frame_done
);

    localparam int CW = $clog2(MAX_LEN + N_REG + 1);

    // First window is complete once N_REG-PAD real samples have been shifted in
    localparam logic [CW-1:0] EMIT_START = CW'(N_REG - PAD);
    localparam logic [CW-1:0] STRIDE_C   = CW'(STRIDE);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] slots [N_REG];
    logic [CW-1:0]    sh_cnt;
    logic [CW-1:0]    out_cnt;
    logic [CW-1:0]    len;
    logic             last_seen;
    logic             in_frame;
    logic             frame_done_q;

    logic             accept;
    logic             start;
    logic             shift_en;
    logic             frame_live;
    logic [CW-1:0]    sh_next;
    logic [CW-1:0]    flush_next;
    logic             final_win;

    function automatic logic emit_cond(input logic [CW-1:0] cnt);
        emit_cond = (cnt >= EMIT_START) &&
                    (((cnt - EMIT_START) % STRIDE_C) == '0);
    endfunction

    assign in_ready   = (state == S_FILL);
    assign accept     = in_valid & in_ready;
    assign start      = accept & in_first;
    assign shift_en   = accept | (state == S_FLUSH);

    // Beats that arrive without a preceding in_first only feed the shift
    // register; they never emit or trigger a flush.
    assign frame_live = start | in_frame;

    assign sh_next    = start ? CW'(1) : (sh_cnt + CW'(1));
    assign flush_next = sh_cnt + CW'(1);

    // Only meaningful once in_last has frozen the frame length.
    assign final_win  = last_seen &&
                        (CW'((out_cnt + CW'(1)) * STRIDE_C) == len);

    assign win_valid  = (state == S_EMIT);
    assign win_last   = (state == S_EMIT) & final_win;
    assign frame_done = frame_done_q;

    genvar g;
    generate
        for (g = 0; g < N_REG; g++) begin : g_pack
            assign win_data[g*WIDTH +: WIDTH] = slots[g];
        end
    endgenerate

    // Shift register: slot 0 oldest, slot N_REG-1 newest. A frame start wipes
    // history so the left padding reads as zeros; flush shifts zeros in to
    // provide the right padding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_REG; k++) begin
                slots[k] <= '0;
            end
        end else if (shift_en) begin
            for (int k = 0; k < N_REG - 1; k++) begin
                slots[k] <= start ? '0 : slots[k+1];
            end
            slots[N_REG-1] <= accept ? in_data : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_FILL;
            sh_cnt       <= '0;
            out_cnt      <= '0;
            len          <= '0;
            last_seen    <= 1'b0;
            in_frame     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                S_FILL: begin
                    if (accept) begin
                        sh_cnt <= sh_next;
                        if (in_first) begin
                            // Also aborts any frame in progress
                            out_cnt   <= '0;
                            len       <= CW'(1);
                            last_seen <= in_last;
                            in_frame  <= 1'b1;
                        end else if (in_frame) begin
                            len       <= len + CW'(1);
                            last_seen <= in_last;
                        end

                        if (frame_live && emit_cond(sh_next)) begin
                            state <= S_EMIT;
                        end else if (frame_live && in_last) begin
                            state <= S_FLUSH;
                        end
                    end
                end

                S_FLUSH: begin
                    sh_cnt <= flush_next;
                    if (emit_cond(flush_next)) begin
                        state <= S_EMIT;
                    end
                end

                S_EMIT: begin
                    if (win_ready) begin
                        out_cnt <= out_cnt + CW'(1);
                        if (final_win) begin
                            state        <= S_FILL;
                            frame_done_q <= 1'b1;
                            in_frame     <= 1'b0;
                        end else if (last_seen) begin
                            state <= S_FLUSH;
                        end else begin
                            state <= S_FILL;
                        end
                    end
                end

                default: begin
                    state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv1d_window_buf.sv
// tb/tb_conv1d_window_buf.sv - self-checking bench for conv1d_window_buf
module tb_conv1d_window_buf;

    localparam int WIDTH   = 32;
    localparam int N_REG   = 31;
    localparam int STRIDE  = 2;
    localparam int PAD     = 15;
    localparam int MAX_LEN = 16384;

    logic                   clk;
    logic                   rst;
    logic [WIDTH-1:0]       in_data;
    logic                   in_valid;
    logic                   in_first;
    logic                   in_last;
    logic                   in_ready;
    logic [N_REG*WIDTH-1:0] win_data;
    logic                   win_valid;
    logic                   win_last;
    logic                   win_ready;
    logic                   frame_done;

    int total = 0;
    int bad   = 0;

    conv1d_window_buf #(
        .WIDTH(WIDTH), .N_REG(N_REG), .STRIDE(STRIDE), .PAD(PAD), .MAX_LEN(MAX_LEN)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .in_ready(in_ready),
        .win_data(win_data), .win_valid(win_valid), .win_last(win_last),
        .win_ready(win_ready), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int len;
        int base;
        int stall_win;
        int stall_cyc;
        int exp_win;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_slot(input int len, input int base, input int w, input int k);
        int j;
        j = STRIDE * w - PAD + k;
        if (j < 0 || j >= len) return '0;
        return WIDTH'(base + j);
    endfunction

    function automatic logic [WIDTH-1:0] slot_of(input int k);
        return win_data[k*WIDTH +: WIDTH];
    endfunction

    task automatic check_window(input string tag, input int len, input int base, input int w);
        int badk;
        int kk;
        badk = -1;
        for (int k = N_REG - 1; k >= 0; k--) begin
            if (slot_of(k) !== exp_slot(len, base, w, k)) badk = k;
        end
        kk = (badk < 0) ? 0 : badk;
        check($sformatf("%s win%0d slot%0d", tag, w, kk), slot_of(kk), exp_slot(len, base, w, kk));
    endtask

    task automatic run_frame(input int len, input int base, input int stall_win,
                             input int stall_cyc, input int exp_win, input string tag);
        int idx = 0;
        int wcnt = 0;
        int stall_left = stall_cyc;
        int cyc = 0;
        bit exp_done = 0;
        bit done_ok = 0;
        logic [N_REG*WIDTH-1:0] snap = '0;
        while (!done_ok && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (exp_done) begin
                check($sformatf("%s frame_done", tag), 32'(frame_done), 32'd1);
                exp_done = 0;
                done_ok = 1;
            end else begin
                check($sformatf("%s no early frame_done", tag), 32'(frame_done), 32'd0);
            end
            win_ready = 1'b1;
            if (win_valid) begin
                check($sformatf("%s in_ready low in emit", tag), 32'(in_ready), 32'd0);
                if (wcnt == stall_win && stall_left > 0) begin
                    win_ready = 1'b0;
                    if (stall_left == stall_cyc) snap = win_data;
                    else check($sformatf("%s stall hold", tag), 32'(win_data == snap), 32'd1);
                    stall_left--;
                end else begin
                    check_window(tag, len, base, wcnt);
                    check($sformatf("%s win%0d last", tag, wcnt), 32'(win_last),
                          32'(wcnt == exp_win - 1));
                    if (wcnt == exp_win - 1) exp_done = 1;
                    wcnt++;
                end
            end
            if (idx < len) begin
                in_valid = 1'b1;
                in_data  = WIDTH'(base + idx);
                in_first = (idx == 0);
                in_last  = (idx == len - 1);
                if (in_ready) idx++;
            end else begin
                in_valid = 1'b0;
                in_first = 1'b0;
                in_last  = 1'b0;
            end
        end
        if (!done_ok) check($sformatf("%s timeout", tag), 32'd0, 32'd1);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check($sformatf("%s idle quiet", tag), 32'(win_valid | frame_done), 32'd0);
        end
        check($sformatf("%s window count", tag), 32'(wcnt), 32'(exp_win));
    endtask

    initial begin
        int idx;
        int cyc;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        win_ready = 1'b1;

        vecs[0] = '{16, 1,   -1, 0, 8};
        vecs[1] = '{16, 1,    3, 5, 8};
        vecs[2] = '{2,  50,  -1, 0, 1};
        vecs[3] = '{32, 200, -1, 0, 16};
        vecs[4] = '{4,  900, -1, 0, 2};

        repeat (2) @(negedge clk);
        check("reset win_valid", 32'(win_valid), 32'd0);
        check("reset win_last", 32'(win_last), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset win_data", 32'(win_data == '0), 32'd1);
        rst = 1'b0;

        // Headless beats (no in_first since reset) must never emit
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'd77;
            in_last  = (i == 19);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("headless no window", 32'(win_valid | frame_done), 32'd0);
        end

        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].len, vecs[v].base, vecs[v].stall_win, vecs[v].stall_cyc,
                      vecs[v].exp_win, $sformatf("vec%0d", v));
        end

        // Abort: 10 beats of a frame, then a new frame restarts it
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort no output", 32'(win_valid | frame_done), 32'd0);
            in_valid = 1'b1;
            in_data  = WIDTH'(500 + i);
            in_first = (i == 0);
            in_last  = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        run_frame(16, 300, -1, 0, 8, "after_abort");

        // Reset while a window is waiting in EMIT
        win_ready = 1'b0;
        idx = 0;
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (win_valid) break;
            if (idx < 16) begin
                in_valid = 1'b1;
                in_data  = WIDTH'(1 + idx);
                in_first = (idx == 0);
                in_last  = (idx == 15);
                if (in_ready) idx++;
            end else begin
                in_valid = 1'b0;
            end
        end
        check("pre-reset in emit", 32'(win_valid), 32'd1);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async rst win_valid", 32'(win_valid), 32'd0);
        check("async rst win_last", 32'(win_last), 32'd0);
        check("async rst frame_done", 32'(frame_done), 32'd0);
        check("async rst in_ready", 32'(in_ready), 32'd1);
        check("async rst win_data", 32'(win_data == '0), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        win_ready = 1'b1;
        run_frame(16, 1, -1, 0, 8, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
